// File: rtl/loa_error_monitor.sv
// loa_error_monitor
// Measures the error of a lower-part-OR (LOA) approximate adder over a batch
// of 2^LOG2_SAMPLES samples. For each accepted sample the exact 17-bit sum of
// a and b is compared with the adder's {approx_carry, approx_sum}. The
// absolute difference (error distance, ED) is then accumulated into the batch
// sum, the nonzero-error count and, optionally, the maximum.
//
// Build option: define LOA_ERR_MAX_EN to add the max_ed port and its register.
//
// Timing: a sample is accepted in cycle c0. Its ED is registered at the end of
// c0 and accumulated at the end of c1. The FSM spends c1 and c2 in DRAIN, and
// done is high from c3 onward.
module loa_error_monitor #(
    parameter int LOG2_SAMPLES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               a,
    input  logic [15:0]               b,
    input  logic [15:0]               approx_sum,
    input  logic                      approx_carry,
    output logic                      done,
    output logic [16+LOG2_SAMPLES:0]  sum_ed,
    output logic [16:0]               mean_ed,
    output logic [LOG2_SAMPLES:0]     err_count
`ifdef LOA_ERR_MAX_EN
    ,
    output logic [16:0]               max_ed
`endif
);

    localparam int SUM_W = 17 + LOG2_SAMPLES;
    localparam int CNT_W = LOG2_SAMPLES + 1;

    // Batch size N and the index of the last sample in a batch.
    localparam logic [CNT_W-1:0] N_SAMPLES   = {1'b1, {LOG2_SAMPLES{1'b0}}};
    localparam logic [CNT_W-1:0] LAST_SAMPLE = {1'b0, {LOG2_SAMPLES{1'b1}}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             drain_cnt_q;
    logic [CNT_W-1:0] sample_cnt_q;
    logic             accept;
    logic             start_run;
    logic [16:0]      exact;
    logic [16:0]      approx;
    logic [16:0]      ed_now;
    logic [16:0]      ed_q;
    logic             ed_vld_q;
    logic [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0] err_q;
`ifdef LOA_ERR_MAX_EN
    logic [16:0]      max_q;
`endif

    // Handshake. start is honoured only in IDLE and DONE.
    assign in_ready  = (state_q == RUN) && (sample_cnt_q < N_SAMPLES);
    assign accept    = in_valid && in_ready;
    assign start_run = start && ((state_q == IDLE) || (state_q == DONE));
    assign done      = (state_q == DONE);

    // Error distance of the sample currently on the inputs.
    // Either result can be the larger one, so subtract in the right order.
    assign exact  = {1'b0, a} + {1'b0, b};
    assign approx = {approx_carry, approx_sum};
    assign ed_now = (exact >= approx) ? (exact - approx) : (approx - exact);

    // Next-state logic for the batch controller.
    always_comb begin
        // NOTE: state_d takes a default before the case so that no path leaves it unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && (sample_cnt_q == LAST_SAMPLE)) state_d = DRAIN;
            DRAIN:   if (drain_cnt_q) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // State register and the counter that times the two DRAIN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= IDLE;
            drain_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= (state_q == DRAIN) ? ~drain_cnt_q : 1'b0;
        end
    end

    // Count accepted samples. Starting a batch clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
        end else if (start_run) begin
            sample_cnt_q <= '0;
        end else if (accept) begin
            sample_cnt_q <= sample_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline stage 1: register the ED of each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ed_q     <= '0;
            ed_vld_q <= 1'b0;
        end else begin
            ed_vld_q <= accept;
            if (accept) begin
                ed_q <= ed_now;
            end
        end
    end

    // Pipeline stage 2: accumulate the batch statistics.
    // Starting a batch clears them. Outside RUN and DRAIN they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            err_q <= '0;
        end else if (start_run) begin
            sum_q <= '0;
            err_q <= '0;
        end else if (ed_vld_q) begin
            sum_q <= sum_q + SUM_W'(ed_q);
            if (ed_q != 17'd0) begin
                err_q <= err_q + CNT_W'(1);
            end
        end
    end

`ifdef LOA_ERR_MAX_EN
    // Track the largest ED seen in the batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else if (start_run) begin
            max_q <= '0;
        end else if (ed_vld_q && (ed_q > max_q)) begin
            max_q <= ed_q;
        end
    end

    assign max_ed = max_q;
`endif

    assign sum_ed    = sum_q;
    assign mean_ed   = sum_q[SUM_W-1:LOG2_SAMPLES];
    assign err_count = err_q;

endmodule

// File: doc/loa_error_monitor.md
LOA_ERROR_MONITOR -- requirements
Module: loa_error_monitor

Interface
REQ-001 Parameter LOG2_SAMPLES, default 8, meaning: the block averages over a batch of N = 2^LOG2_SAMPLES samples, legal range 1..16.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse that begins a new batch.
REQ-005 in_valid  input  1  sample present on a, b, approx_sum and approx_carry.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 a, b  input  16 each  operands given to the LOA adder.
REQ-008 approx_sum  input  16  LOA sum output.
REQ-009 approx_carry  input  1  LOA carry output.
REQ-010 done  output  1  batch statistics valid; held high as a level.
REQ-011 sum_ed  output  17+LOG2_SAMPLES  accumulated error distance.
REQ-012 mean_ed  output  17  equals sum_ed >> LOG2_SAMPLES.
REQ-013 err_count  output  LOG2_SAMPLES+1  number of samples with nonzero error distance.
REQ-014 max_ed  output  17  largest error distance in the batch; present only when LOA_ERR_MAX_EN is defined.

Function
REQ-015 Exact result: exact = {1'b0,a} + {1'b0,b}, 17 bits.
REQ-016 Approximate result: approx = {approx_carry, approx_sum}, 17 bits.
REQ-017 Error distance: ED = |exact - approx|, unsigned 17 bits; either operand may be the larger.
REQ-018 State machine states: IDLE, RUN, DRAIN, DONE.
REQ-019 Transitions: IDLE -> RUN on start; RUN -> DRAIN when the Nth sample is accepted; DRAIN -> DONE after 2 cycles; DONE -> RUN on start.
REQ-020 start is ignored in RUN and DRAIN.
REQ-021 Entering RUN clears sum_ed, err_count, max_ed and the sample counter in the same edge.
REQ-022 in_ready = 1 only in RUN and only while the accepted-sample count < N.
REQ-023 A sample is accepted on a rising edge where in_valid && in_ready.
REQ-024 in_valid while in_ready = 0 is ignored; there is no buffering.
REQ-025 Pipeline: ED is registered 1 cycle after acceptance and accumulated 2 cycles after acceptance.
REQ-026 Pipeline throughput: one sample per cycle.
REQ-027 Accumulator width: sum_ed is wide enough that N samples of maximum ED (2^17-1) cannot overflow.
REQ-028 err_count increments by 1 per accumulated sample with ED != 0, reaching at most N.
REQ-029 done = 1 exactly in DONE; it rises 3 cycles after the Nth acceptance.
REQ-030 Output hold: sum_ed, mean_ed, err_count and max_ed hold their values in DONE and IDLE.
REQ-031 In RUN, the statistic outputs show running partial values.
REQ-032 A start in the same cycle as the last drain cycle is ignored; start must be given again in DONE.

Reset
REQ-033 On rst_n low, the block immediately goes to IDLE and all outputs read 0 (in_ready, done, sum_ed, mean_ed, err_count, max_ed).
REQ-034 Reset mid-batch discards all partial statistics and in-flight pipeline samples.
REQ-035 After reset release, the block waits in IDLE for start.

Configuration
REQ-036 Macro LOA_ERR_MAX_EN defined: the max_ed port and a 17-bit max register are present; the register updates to max(max_ed, ED) at each accumulation.
REQ-037 Macro LOA_ERR_MAX_EN undefined: the max_ed port and its logic are absent; all other behaviour is identical.

Verification
REQ-038 Reset stimulus: rst_n low for 3 cycles, then high, no start -> in_ready = 0, done = 0, all statistics 0, state IDLE.
REQ-039 Single-error stimulus (LOG2_SAMPLES = 1): start, then 2 samples a=0x00FF, b=0x0001, approx=0x000FF -> each ED = 1; sum_ed = 2, mean_ed = 1, err_count = 2, done rises 3 cycles after the 2nd acceptance.
REQ-040 Carry-overestimate stimulus (LOG2_SAMPLES = 1): a=0x0080, b=0x0080, approx=0x00180, then a=0x1234, b=0x0000, approx=0x01234 -> sum_ed = 0x80, mean_ed = 0x40, err_count = 1, max_ed = 0x80 when LOA_ERR_MAX_EN is defined.
REQ-041 Backpressure stimulus (default N = 256): in_valid held high for 300 cycles -> exactly 256 acceptances, in_ready low after the 256th acceptance, no further accumulation.
REQ-042 Mid-batch reset stimulus: assert rst_n low after 100 samples -> outputs 0 immediately; a new batch started afterwards gives results equal to a fresh run.
REQ-043 Restart stimulus: start in DONE -> statistics clear on the next edge and in_ready = 1; start pulsed during RUN -> no effect on the counts.
